shift_mux_pipeline: RTL
=======================

// Module: shift_mux_pipeline
// PURPOSE
// - Pipelined logarithmic right-shifter for the significand path. It sits between the
//   two bit-reversal mux arrays: the first array feeds Data_i, and Data_o feeds the
//   second array.
// - A left shift is built as reverse -> right shift -> reverse. For that, this block
//   carries the direction flag alongside the data, so the downstream reversal select
//   stays aligned with the data.
// - One registered level per shift-amount bit. Supports a global stall via load_i.
// PARAMETERS
// - SWR  default 26  significand datapath width in bits
// - EWR  default 5   shift-amount width; also the number of pipeline levels (latency)
// PORTS
// - clk           in   1    system clock; all state updates on the rising edge
// - rst           in   1    synchronous, active-high reset
// - load_i        in   1    advance enable: 1 = all levels advance, 0 = all levels hold
// - valid_i       in   1    Data_i / Shift_Value_i / Left_Right_i / Bit_Shift_i qualify
// - Data_i        in   SWR  operand, already bit-reversed upstream when shifting left
// - Shift_Value_i in   EWR  unsigned shift amount, 0..2^EWR-1
// - Left_Right_i  in   1    direction tag, pipelined unchanged (1 = left, reversal needed)
// - Bit_Shift_i   in   1    fill bit injected at the MSB end of every shifted level
// - Data_o        out  SWR  shifted result
// - valid_o       out  1    Data_o / Left_Right_o qualify
// - Left_Right_o  out  1    direction tag aligned with Data_o; drives the downstream select
// BEHAVIOUR
// - Reset
//   - rst=1 at a clock edge clears every level register.
//   - This covers data, shift bits, fill bit, direction and valid.
//   - Result: Data_o=0, valid_o=0, Left_Right_o=0.
//   - rst has priority over load_i.
// - Level k (k=0..EWR-1), registered when load_i=1:
//   - Inputs: D(k-1), S(k-1), F(k-1), L(k-1), V(k-1). Level -1 is the port inputs.
//   - D(k) = S(k-1)[k] ? {2^k copies of F, D(k-1)[SWR-1:2^k]} : D(k-1).
//   - If 2^k >= SWR and the bit is set: D(k) = all F.
//   - Remaining shift bits, F, L and V are registered alongside D(k).
// - Latency
//   - Exactly EWR load_i=1 edges from capture to output.
//   - Data_o = D(EWR-1), valid_o = V(EWR-1), Left_Right_o = L(EWR-1).
//   - Net result: Data_i >> Shift_Value_i, with Bit_Shift_i filling the vacated MSBs.
//   - Shift_Value_i >= SWR yields all-fill; this is legal, not an error.
// - Stall
//   - load_i=0 freezes every level, including valid bits.
//   - Outputs stay stable for as long as load_i=0.
//   - No data is lost or duplicated across a stall.
// - Invalid slots
//   - valid_i=0 slots still propagate; their data is don't-care.
//   - valid_o must be 0 for them.
//   - Back-to-back valid inputs give one result per load_i=1 cycle.
// - No combinational path from any input to any output.
// - Reset mid-operation
//   - All in-flight entries are discarded.
//   - valid_o=0 on the cycle after the rst edge.
//   - It stays 0 until a new entry has traversed EWR levels.
// - Simultaneous rst=1 and load_i=1 with valid_i=1: reset wins; the input is dropped.
// TESTING
// - Reset with pipeline full
//   - Stimulus: rst=1 for 1 cycle while the pipeline is full.
//   - Required: Data_o=0, valid_o=0, Left_Right_o=0 next cycle.
//   - Required: valid_o stays 0 for EWR load cycles.
// - Basic shift and latency
//   - Stimulus: SWR=26, EWR=5; Data_i=26'h3FFFFFF, Shift_Value_i=3, Bit_Shift_i=0, load_i=1.
//   - Required: after 5 edges, Data_o=26'h07FFFFF, valid_o=1.
// - Maximum shift with fill
//   - Stimulus: Data_i=26'h2AAAAAA, Shift_Value_i=31, Bit_Shift_i=1.
//   - Required: Data_o=26'h3FFFFFF.
//   - Also: Shift_Value_i=0 returns Data_i unchanged.
// - Back-to-back streaming
//   - Stimulus: back-to-back valid inputs with shifts 0..25, Left_Right_i alternating.
//   - Required: each output matches the reference model, in order, 1 per cycle.
//   - Required: Left_Right_o aligned with its data.
// - Stall
//   - Stimulus: load_i=0 for 4 cycles mid-stream.
//   - Required: Data_o / valid_o / Left_Right_o frozen during the stall.
//   - Required: the stream resumes with no drop or duplicate.
// - Reset versus load
//   - Stimulus: rst=1 and load_i=1 with valid_i=1 on the same edge.
//   - Required: that entry never appears at the output (valid_o stays 0 for it).

Source files
------------

// File: rtl/shift_mux_pipeline_if.sv
// -----------------------------------------------------------------------------
// shift_mux_pipeline_if
// Bundles the stream signals of the pipelined right-shifter.
//
// Handshake: there is no per-slot back-pressure. load_i is a global advance
// enable shared by every level. A slot is accepted on a rising clock edge when
// load_i=1, whatever the value of valid_i. valid_i only tags the slot as
// meaningful. A slot marked valid_i=1 comes out exactly EWR load_i=1 edges
// later, with valid_o=1. While load_i=0, nothing moves and the outputs hold.
//
// Signals (direction as seen by the shifter, modport slave):
//   load_i        in   1    advance enable for all levels
//   valid_i       in   1    qualifies the input slot
//   Data_i        in   SWR  operand (pre-reversed upstream for left shifts)
//   Shift_Value_i in   EWR  unsigned shift amount
//   Left_Right_i  in   1    direction tag, carried unchanged
//   Bit_Shift_i   in   1    fill bit for the vacated MSBs
//   Data_o        out  SWR  shifted result
//   valid_o       out  1    qualifies Data_o / Left_Right_o
//   Left_Right_o  out  1    direction tag aligned with Data_o
// -----------------------------------------------------------------------------
interface shift_mux_pipeline_if #(
    parameter int SWR = 26,
    parameter int EWR = 5
) ();
    logic           load_i;
    logic           valid_i;
    logic [SWR-1:0] Data_i;
    logic [EWR-1:0] Shift_Value_i;
    logic           Left_Right_i;
    logic           Bit_Shift_i;
    logic [SWR-1:0] Data_o;
    logic           valid_o;
    logic           Left_Right_o;

    modport master (
        output load_i, valid_i, Data_i, Shift_Value_i, Left_Right_i, Bit_Shift_i,
        input  Data_o, valid_o, Left_Right_o
    );

    modport slave (
        input  load_i, valid_i, Data_i, Shift_Value_i, Left_Right_i, Bit_Shift_i,
        output Data_o, valid_o, Left_Right_o
    );
endinterface

// File: rtl/shift_mux_pipeline.sv
// -----------------------------------------------------------------------------
// shift_mux_pipeline
// Pipelined logarithmic right-shifter for the significand path. Level k shifts
// right by 2^k when bit k of the shift amount is set, and fills the vacated MSBs
// with the fill bit. Each level is one register stage, so the latency is EWR
// load_i=1 edges. The direction tag is carried alongside the data so that the
// downstream reversal mux select stays aligned with the data.
//
// Ports:
//   clk   in  1   rising-edge clock
//   rst   in  1   synchronous, active-high; clears every level, wins over load_i
//   bus   slave modport of shift_mux_pipeline_if (stream in / result out)
//
// This structure requires EWR >= 2.
// -----------------------------------------------------------------------------
module shift_mux_pipeline #(
    parameter int SWR = 26,
    parameter int EWR = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    shift_mux_pipeline_if.slave  bus
);
    localparam logic [SWR-1:0] ONES = {SWR{1'b1}};

    // Level registers. The shift amount is stored pre-shifted by one position
    // per level, so each level always consumes bit 0. The last level consumes
    // neither shift bits nor the fill bit, so those arrays stop one level short.
    logic [SWR-1:0] data_q [EWR];
    logic [SWR-1:0] data_d [EWR];
    logic [EWR-1:0] sh_q   [EWR-1];
    logic [EWR-1:0] sh_d   [EWR-1];
    logic [EWR-2:0] fill_q, fill_d;
    logic [EWR-1:0] lr_q,   lr_d;
    logic [EWR-1:0] valid_q, valid_d;

    // Per-level inputs: index 0 is the port side, index k is level k-1.
    logic [SWR-1:0] d_in [EWR];
    logic [EWR-1:0] s_in [EWR];
    logic [EWR-1:0] f_in;

    always_comb begin
        d_in[0] = bus.Data_i;
        s_in[0] = bus.Shift_Value_i;
        f_in[0] = bus.Bit_Shift_i;
        for (int k = 1; k < EWR; k++) begin
            d_in[k] = data_q[k-1];
            s_in[k] = sh_q[k-1];
            f_in[k] = fill_q[k-1];
        end

        for (int k = 0; k < EWR; k++) begin
            // A shift count >= SWR clears the data and makes the mask all ones,
            // which yields the all-fill result without a special case.
            if (s_in[k][0]) begin
                data_d[k] = (d_in[k] >> (1 << k)) |
                            (f_in[k] ? ~(ONES >> (1 << k)) : '0);
            end else begin
                data_d[k] = d_in[k];
            end
        end

        for (int k = 0; k < EWR - 1; k++) begin
            sh_d[k]   = s_in[k] >> 1;
            fill_d[k] = f_in[k];
        end

        lr_d[0]    = bus.Left_Right_i;
        valid_d[0] = bus.valid_i;
        for (int k = 1; k < EWR; k++) begin
            lr_d[k]    = lr_q[k-1];
            valid_d[k] = valid_q[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < EWR; k++) begin
                data_q[k] <= '0;
            end
            for (int k = 0; k < EWR - 1; k++) begin
                sh_q[k] <= '0;
            end
            fill_q  <= '0;
            lr_q    <= '0;
            valid_q <= '0;
        end else if (bus.load_i) begin
            for (int k = 0; k < EWR; k++) begin
                data_q[k] <= data_d[k];
            end
            for (int k = 0; k < EWR - 1; k++) begin
                sh_q[k] <= sh_d[k];
            end
            fill_q  <= fill_d;
            lr_q    <= lr_d;
            valid_q <= valid_d;
        end
    end

    assign bus.Data_o       = data_q[EWR-1];
    assign bus.valid_o      = valid_q[EWR-1];
    assign bus.Left_Right_o = lr_q[EWR-1];
endmodule
